ts_sync_aligner: RTL and testbench

- Upstream stage of the TS processing RAM block (logic_ram).
- Takes a raw, unaligned MPEG-TS byte stream (for example from a tuner or SPI/parallel TS interface) and hunts for the 0x47 sync byte at a fixed packet spacing.
- Declares lock after repeated confirmation.
- Once locked, emits whole 188-byte packets on the mpeg_data/mpeg_valid/mpeg_sync interface that logic_ram consumes.

---
 rtl/ts_sync_aligner_pkg.sv | 14 +
 rtl/ts_sync_aligner_if.sv | 27 ++
 rtl/ts_sync_aligner_checker.sv | 68 ++++++
 rtl/ts_sync_aligner.sv | 185 ++++++++++++++++++
 tb/tb_ts_sync_aligner.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_sync_aligner_pkg.sv
// Shared constants and state type for the TS sync aligner.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam int unsigned TS_PKT_188   = 188;
    localparam int unsigned TS_PKT_204   = 204;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

endpackage

// File: rtl/ts_sync_aligner_if.sv
// Raw TS input / aligned TS output bundle of the aligner.
// TS_SYNC_204_EN adds the pkt204 mode flag.
interface ts_sync_aligner_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic [7:0]           in_data;
    logic                 in_valid;
    logic [7:0]           mpeg_data;
    logic                 mpeg_valid;
    logic                 mpeg_sync;
    logic                 locked;
    logic                 sync_err;
    logic [CNT_WIDTH-1:0] lost_cnt;
`ifdef TS_SYNC_204_EN
    logic                 pkt204;

    modport master (input in_data, in_valid,
                    output mpeg_data, mpeg_valid, mpeg_sync, locked, sync_err, lost_cnt, pkt204);
    modport slave  (output in_data, in_valid,
                    input mpeg_data, mpeg_valid, mpeg_sync, locked, sync_err, lost_cnt, pkt204);
`else
    modport master (input in_data, in_valid,
                    output mpeg_data, mpeg_valid, mpeg_sync, locked, sync_err, lost_cnt);
    modport slave  (output in_data, in_valid,
                    input mpeg_data, mpeg_valid, mpeg_sync, locked, sync_err, lost_cnt);
`endif
endinterface

// File: rtl/ts_sync_aligner_checker.sv
// Position counter, good-sync counter and boundary compare for one packet spacing.
module ts_sync_checker
    import ts_pkg::*;
#(
    parameter int unsigned SPACING    = TS_PKT_188,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned SKIP_FROM  = TS_PKT_188
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_i,
    input  logic       start_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       boundary_c_o,
    output logic       hit_c_o,
    output logic       lock_c_o,
    output logic       alive_c_o,
    output logic       skip_c_o
);
    localparam int unsigned CW = $clog2(SPACING);
    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic          alive_q, alive_d;
    logic          miss_c;

    // cnt_q is the packet position of the byte currently on data_i
    assign boundary_c_o = run_i && valid_i && (cnt_q == '0);
    assign hit_c_o      = boundary_c_o && (data_i == TS_SYNC_BYTE);
    assign miss_c       = boundary_c_o && (data_i != TS_SYNC_BYTE);
    assign lock_c_o     = hit_c_o && alive_q && (good_q >= GW'(LOCK_COUNT - 1));
    assign alive_c_o    = alive_q && !miss_c;
    assign skip_c_o     = cnt_q >= CW'(SKIP_FROM);

    always_comb begin
        cnt_d   = cnt_q;
        good_d  = good_q;
        alive_d = alive_q;
        if (start_i) begin
            cnt_d   = CW'(1);
            good_d  = GW'(1);
            alive_d = 1'b1;
        end else if (!run_i) begin
            cnt_d   = '0;
            good_d  = '0;
            alive_d = 1'b0;
        end else if (valid_i) begin
            cnt_d   = (cnt_q == CW'(SPACING - 1)) ? '0 : cnt_q + CW'(1);
            alive_d = alive_c_o;
            if (hit_c_o && (good_q != GW'(LOCK_COUNT))) good_d = good_q + GW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            good_q  <= '0;
            alive_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            alive_q <= alive_d;
        end
    end

endmodule

// File: rtl/ts_sync_aligner.sv
// Hunts the 0x47 sync in a raw TS byte stream, locks, and emits aligned packets to logic_ram.
// TS_SYNC_204_EN additionally locks to 204-byte packets and strips the RS parity.
module ts_sync_aligner
    import ts_pkg::*;
#(
    parameter int unsigned PACK_BYTE_SIZE = TS_PKT_188,
    parameter int unsigned LOCK_COUNT     = 3,
    parameter int unsigned UNLOCK_COUNT   = 3,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    ts_sync_aligner_if.master bus
);
    localparam int unsigned MW = $clog2(UNLOCK_COUNT + 1);

    sync_state_t          state_q, state_d;
    logic [MW-1:0]        miss_q, miss_d;
    logic [CNT_WIDTH-1:0] lost_q, lost_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 sync_q, sync_d;
    logic                 err_q, err_d;
    logic                 locked_q;

    logic run_c, is_sync_c, start_c;
    logic bnd188_c, hit188_c, lock188_c, alive188_c, skip188_c;
    logic bnd_c, hit_c, skip_c, lock_any_c, alive_any_c;

    assign is_sync_c = bus.in_data == TS_SYNC_BYTE;
    assign run_c     = state_q != HUNT;
    assign start_c   = (state_q == HUNT) && bus.in_valid && is_sync_c;

    ts_sync_checker #(
        .SPACING    (PACK_BYTE_SIZE),
        .LOCK_COUNT (LOCK_COUNT),
        .SKIP_FROM  (PACK_BYTE_SIZE)
    ) u_chk188 (
        .clk          (S_AXI_ACLK),
        .rst_n        (S_AXI_ARESETN),
        .run_i        (run_c),
        .start_i      (start_c),
        .valid_i      (bus.in_valid),
        .data_i       (bus.in_data),
        .boundary_c_o (bnd188_c),
        .hit_c_o      (hit188_c),
        .lock_c_o     (lock188_c),
        .alive_c_o    (alive188_c),
        .skip_c_o     (skip188_c)
    );

`ifdef TS_SYNC_204_EN
    logic bnd204_c, hit204_c, lock204_c, alive204_c, skip204_c;
    logic len204_q, len204_d, pkt204_q;

    ts_sync_checker #(
        .SPACING    (TS_PKT_204),
        .LOCK_COUNT (LOCK_COUNT),
        .SKIP_FROM  (PACK_BYTE_SIZE)
    ) u_chk204 (
        .clk          (S_AXI_ACLK),
        .rst_n        (S_AXI_ARESETN),
        .run_i        (run_c),
        .start_i      (start_c),
        .valid_i      (bus.in_valid),
        .data_i       (bus.in_data),
        .boundary_c_o (bnd204_c),
        .hit_c_o      (hit204_c),
        .lock_c_o     (lock204_c),
        .alive_c_o    (alive204_c),
        .skip_c_o     (skip204_c)
    );

    assign bnd_c       = len204_q ? bnd204_c  : bnd188_c;
    assign hit_c       = len204_q ? hit204_c  : hit188_c;
    assign skip_c      = len204_q ? skip204_c : skip188_c;
    assign lock_any_c  = lock188_c || lock204_c;
    assign alive_any_c = alive188_c || alive204_c;

    // 188 spacing wins if both spacings confirm on the same byte
    always_comb begin
        len204_d = len204_q;
        if ((state_q == VERIFY) && bus.in_valid && lock_any_c) len204_d = !lock188_c;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            len204_q <= 1'b0;
            pkt204_q <= 1'b0;
        end else begin
            len204_q <= len204_d;
            pkt204_q <= (state_d == LOCKED) && len204_d;
        end
    end

    assign bus.pkt204 = pkt204_q;
`else
    assign bnd_c       = bnd188_c;
    assign hit_c       = hit188_c;
    assign skip_c      = skip188_c;
    assign lock_any_c  = lock188_c;
    assign alive_any_c = alive188_c;
`endif

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        lost_d  = lost_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sync_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: if (is_sync_c) state_d = VERIFY;
                VERIFY: begin
                    if (lock_any_c) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                        valid_d = 1'b1;
                        sync_d  = 1'b1;
                        data_d  = bus.in_data;
                    end else if (!alive_any_c) begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (bnd_c && hit_c) begin
                        miss_d  = '0;
                        valid_d = 1'b1;
                        sync_d  = 1'b1;
                        data_d  = bus.in_data;
                    end else if (bnd_c) begin
                        // flywheel over a bad sync until too many in a row
                        err_d = 1'b1;
                        if (miss_q >= MW'(UNLOCK_COUNT - 1)) begin
                            state_d = HUNT;
                            miss_d  = '0;
                            if (lost_q != '1) lost_d = lost_q + CNT_WIDTH'(1);
                        end else begin
                            miss_d  = miss_q + MW'(1);
                            valid_d = 1'b1;
                            sync_d  = 1'b1;
                            data_d  = bus.in_data;
                        end
                    end else if (!skip_c) begin
                        valid_d = 1'b1;
                        data_d  = bus.in_data;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q  <= HUNT;
            miss_q   <= '0;
            lost_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sync_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            miss_q   <= miss_d;
            lost_q   <= lost_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sync_q   <= sync_d;
            err_q    <= err_d;
            locked_q <= state_d == LOCKED;
        end
    end

    assign bus.mpeg_data  = data_q;
    assign bus.mpeg_valid = valid_q;
    assign bus.mpeg_sync  = sync_q;
    assign bus.sync_err   = err_q;
    assign bus.locked     = locked_q;
    assign bus.lost_cnt   = lost_q;

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Directed bench for ts_sync_aligner with a per-cycle packet-position model.
module tb_ts_sync_aligner;

    localparam int LOCK   = 3;
    localparam int UNLOCK = 3;
`ifdef TS_SYNC_204_EN
    localparam int NC = 2;
`else
    localparam int NC = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ts_sync_aligner_if #(.CNT_WIDTH(16)) bus ();

    ts_sync_aligner #(
        .PACK_BYTE_SIZE (188),
        .LOCK_COUNT     (LOCK),
        .UNLOCK_COUNT   (UNLOCK),
        .CNT_WIDTH      (16)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .bus           (bus)
    );

    int checks = 0;
    int passes = 0;

    // model: mode 0 hunt, 1 verify, 2 locked; positions are accepted-byte indices
    int m_mode, m_n, m_anchor, m_len, m_miss, m_lost;
    int m_alive [2];
    int m_good  [2];
    bit e_valid, e_sync, e_err;
    logic [7:0] e_data;

    int out_cnt, sync_cnt, err_cnt, lock_at, acc_idx;
    bit first_seen;
    logic [7:0] first_data;
    logic first_sync;

    logic [7:0] junk [5] = '{8'h11, 8'h22, 8'h47, 8'h33, 8'h44};

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, exp, $time);
    endfunction

    function automatic int spacing(int i);
        return (i == 0) ? 188 : 204;
    endfunction

    function automatic logic [7:0] payload(int k, int p);
        logic [7:0] v;
        v = 8'(k * 31 + p * 7 + 1);
        if (v == 8'h47) v = 8'h48;
        return v;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_n = 0; m_anchor = 0; m_len = 188; m_miss = 0; m_lost = 0;
        for (int i = 0; i < 2; i++) begin m_alive[i] = 0; m_good[i] = 0; end
        e_valid = 0; e_sync = 0; e_err = 0; e_data = 8'h00;
    endfunction

    function automatic void emit(logic [7:0] b, bit s);
        e_valid = 1; e_sync = s; e_data = b;
    endfunction

    function automatic void model_step(bit v, logic [7:0] b);
        int  ph;
        bit  done;
        bit  any;
        e_valid = 0; e_sync = 0; e_err = 0;
        if (v) begin
            if (m_mode == 0) begin
                if (b == 8'h47) begin
                    m_mode = 1; m_anchor = m_n;
                    for (int i = 0; i < NC; i++) begin m_alive[i] = 1; m_good[i] = 1; end
                end
            end else if (m_mode == 1) begin
                done = 0; any = 0;
                for (int i = 0; i < NC; i++) begin
                    if (!done && m_alive[i] != 0 && ((m_n - m_anchor) % spacing(i)) == 0) begin
                        if (b == 8'h47) begin
                            m_good[i]++;
                            if (m_good[i] == LOCK) begin done = 1; m_len = spacing(i); end
                        end else m_alive[i] = 0;
                    end
                    if (m_alive[i] != 0) any = 1;
                end
                if (done) begin m_mode = 2; m_miss = 0; emit(b, 1); end
                else if (!any) m_mode = 0;
            end else begin
                ph = (m_n - m_anchor) % m_len;
                if (ph == 0) begin
                    if (b == 8'h47) begin m_miss = 0; emit(b, 1); end
                    else begin
                        e_err = 1; m_miss++;
                        if (m_miss == UNLOCK) begin m_mode = 0; m_miss = 0; m_lost++; end
                        else emit(b, 1);
                    end
                end else if (ph < 188) emit(b, 0);
            end
            m_n++;
        end
    endfunction

    // one cycle: drive, let the DUT clock it, then compare against the model
    task automatic step(bit v, logic [7:0] b);
        bus.in_valid = v;
        bus.in_data  = b;
        @(posedge clk);
        model_step(v, b);
        @(negedge clk);
        chk("mpeg_valid", 32'(bus.mpeg_valid), 32'(e_valid));
        chk("mpeg_sync",  32'(bus.mpeg_sync),  32'(e_sync));
        if (e_valid) chk("mpeg_data", 32'(bus.mpeg_data), 32'(e_data));
        chk("sync_err", 32'(bus.sync_err), 32'(e_err));
        chk("locked",   32'(bus.locked),   32'(m_mode == 2));
        chk("lost_cnt", 32'(bus.lost_cnt), 32'(m_lost));
`ifdef TS_SYNC_204_EN
        chk("pkt204", 32'(bus.pkt204), 32'(m_mode == 2 && m_len == 204));
`endif
        if (bus.mpeg_valid) out_cnt++;
        if (bus.mpeg_sync)  sync_cnt++;
        if (bus.sync_err)   err_cnt++;
        if (bus.mpeg_valid && !first_seen) begin
            first_seen = 1; first_data = bus.mpeg_data; first_sync = bus.mpeg_sync;
        end
        if (v) begin
            if (bus.locked && lock_at < 0) lock_at = acc_idx;
            acc_idx++;
        end
    endtask

    task automatic send_pkt(int k, logic [7:0] sb, int len, int nbytes, bit gaps);
        logic [7:0] b;
        int g;
        for (int p = 0; p < nbytes; p++) begin
            if (gaps) begin
                g = 0;
                while (g < 4 && $urandom_range(0, 1) == 1) begin step(0, 8'h00); g++; end
            end
            b = (p == 0) ? sb : ((p >= 188) ? 8'hEE : payload(k, p));
            step(1, b);
        end
    endtask

    task automatic begin_scn();
        out_cnt = 0; sync_cnt = 0; err_cnt = 0; lock_at = -1; acc_idx = 0; first_seen = 0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid",  32'(bus.mpeg_valid), 0);
        chk("rst_sync",   32'(bus.mpeg_sync),  0);
        chk("rst_data",   32'(bus.mpeg_data),  0);
        chk("rst_err",    32'(bus.sync_err),   0);
        chk("rst_locked", 32'(bus.locked),     0);
        chk("rst_lost",   32'(bus.lost_cnt),   0);
        rst_n = 1'b1;
        model_reset();
        begin_scn();
    endtask

    initial begin
        // clean stream: lock on the third sync, packets 2..6 out
        do_reset();
        for (int k = 0; k < 7; k++) send_pkt(k, 8'h47, 188, 188, 0);
        chk("s1_lock_at", 32'(lock_at), 376);
        chk("s1_out",     32'(out_cnt), 940);
        chk("s1_syncs",   32'(sync_cnt), 5);
        chk("s1_errs",    32'(err_cnt), 0);

        // junk with a stray sync ahead of an aligned stream
        do_reset();
        for (int j = 0; j < 5; j++) step(1, junk[j]);
        for (int k = 0; k < 5; k++) send_pkt(k, 8'h47, 188, 188, 0);
        chk("s2_first_data", 32'(first_data), 32'h47);
        chk("s2_first_sync", 32'(first_sync), 1);
`ifdef TS_SYNC_204_EN
        chk("s2_out", 32'(out_cnt), 188);
`else
        chk("s2_out", 32'(out_cnt), 376);
`endif

        // isolated bad syncs separated by good ones never unlock
        do_reset();
        for (int k = 0; k < 9; k++)
            send_pkt(k, (k == 4 || k == 6 || k == 8) ? 8'h00 : 8'h47, 188, 188, 0);
        chk("s3_errs",   32'(err_cnt), 3);
        chk("s3_out",    32'(out_cnt), 1316);
        chk("s3_syncs",  32'(sync_cnt), 7);
        chk("s3_locked", 32'(bus.locked), 1);
        chk("s3_lost",   32'(bus.lost_cnt), 0);

        // three bad syncs in a row unlock, then re-lock
        do_reset();
        for (int k = 0; k < 11; k++)
            send_pkt(k, (k >= 4 && k <= 6) ? 8'h00 : 8'h47, 188, 188, 0);
        chk("s4_errs",   32'(err_cnt), 3);
        chk("s4_out",    32'(out_cnt), 1128);
        chk("s4_syncs",  32'(sync_cnt), 6);
        chk("s4_lost",   32'(bus.lost_cnt), 1);
        chk("s4_locked", 32'(bus.locked), 1);

        // random input gaps
        do_reset();
        for (int k = 0; k < 6; k++) send_pkt(k, 8'h47, 188, 188, 1);
        chk("s5_out",   32'(out_cnt), 752);
        chk("s5_syncs", 32'(sync_cnt), 4);

`ifdef TS_SYNC_204_EN
        // 204-byte packets: parity stripped, 188-byte packets out
        do_reset();
        for (int k = 0; k < 6; k++) send_pkt(k, 8'h47, 204, 204, 0);
        chk("s6_lock_at", 32'(lock_at), 408);
        chk("s6_out",     32'(out_cnt), 752);
        chk("s6_syncs",   32'(sync_cnt), 4);
        chk("s6_pkt204",  32'(bus.pkt204), 1);
`endif

        // asynchronous reset mid-packet
        do_reset();
        for (int k = 0; k < 3; k++) send_pkt(k, 8'h47, 188, 188, 0);
        send_pkt(3, 8'h47, 188, 100, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(posedge clk);
        #1;
        chk("pre_rst_valid",  32'(bus.mpeg_valid), 1);
        chk("pre_rst_locked", 32'(bus.locked), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  32'(bus.mpeg_valid), 0);
        chk("arst_data",   32'(bus.mpeg_data), 0);
        chk("arst_locked", 32'(bus.locked), 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        begin_scn();
        for (int j = 0; j < 3; j++) step(1, 8'h00);
        for (int k = 0; k < 4; k++) send_pkt(k, 8'h47, 188, 188, 0);
        chk("s7_lock_at", 32'(lock_at), 379);
        chk("s7_out",     32'(out_cnt), 376);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
